mac_ram_bank: RTL and testbench

- Parametrised RAM-based multiply-accumulate bank for the correlator datapath; successor to the fixed 8-bit/32-bit/256-lag bank.
- Each accepted sample triggers one full sweep: lag k accumulates a_held * b_k, where b_k is the shift-input value presented on sweep cycle k.
- Adds signed mode, saturation with sticky overflow, a busy/done handshake, dropped-sample detection and a pipelined read port.

---
 rtl/mac_ram_bank.sv | 243 ++++++++++++++++++++++++
 tb/tb_mac_ram_bank.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_ram_bank.sv
// -----------------------------------------------------------------------------
// mac_ram_bank
//   RAM-based multiply-accumulate bank for the correlator datapath.
//   Each accepted sample strobe runs one sweep over all 2**LAG_LOG2 lags:
//   lag k accumulates a_held * b_k, where b_k is the shift input presented
//   on sweep cycle k (sweep cycle 0 is the accept cycle itself).
//
// Parameters
//   DW        operand width of a and b
//   ACC_W     accumulator width (>= 2*DW)
//   LAG_LOG2  log2 of the number of accumulators
//   SIGNED    1 = two's complement operands/accumulators, 0 = unsigned
//   SATURATE  1 = clamp on overflow, 0 = wrap modulo 2**ACC_W
//
// Ports
//   clk, rst_n      clock (rising edge) / asynchronous active-low reset
//   sin, a, b       sample strobe, multiplicand (held), per-lag shift input
//   clr_req         start a sweep that zeroes every accumulator
//   busy, done      sweep in progress / one-cycle end-of-sweep pulse
//   drop, ovf       sticky: sample lost / accumulator overflowed
//   rd_req, rd_addr read request; rd_valid/rd_data appear two cycles later
// -----------------------------------------------------------------------------
module mac_ram_bank #(
    parameter int DW       = 8,
    parameter int ACC_W    = 32,
    parameter int LAG_LOG2 = 8,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sin,
    input  logic                clr_req,
    input  logic [DW-1:0]       a,
    input  logic [DW-1:0]       b,
    output logic                busy,
    output logic                done,
    output logic                drop,
    output logic                ovf,
    input  logic                rd_req,
    input  logic [LAG_LOG2-1:0] rd_addr,
    output logic                rd_valid,
    output logic [ACC_W-1:0]    rd_data
);

    localparam int                  DEPTH  = 2**LAG_LOG2;
    localparam int                  PW     = 2*DW;
    localparam logic                L_SGN  = (SIGNED != 0);
    localparam logic                L_SAT  = (SATURATE != 0);
    localparam logic [LAG_LOG2-1:0] K_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_CLR,
        S_READ
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic [LAG_LOG2-1:0]   r_k;          // write address of the current sweep cycle
    logic [LAG_LOG2-1:0]   w_k_nx;
    logic [DW-1:0]         r_a_hold;
    logic [DW-1:0]         r_b_reg;
    logic                  r_done;
    logic                  r_drop;
    logic                  r_ovf;
    logic                  r_rd_p1;
    logic                  r_rd_valid;
    logic [ACC_W-1:0]      r_rd_data;

    logic [ACC_W-1:0]      r_mem [DEPTH];
    logic [ACC_W-1:0]      r_ram_q;

    logic [LAG_LOG2-1:0]   w_raddr;
    logic                  w_we;
    logic [ACC_W-1:0]      w_wdata;
    logic                  w_accept_mac;
    logic                  w_capture_b;
    logic                  w_rd_issue;
    logic                  w_drop_set;
    logic                  w_sweep_end;

    logic [PW-1:0]         w_a_ext;
    logic [PW-1:0]         w_b_ext;
    logic [PW-1:0]         w_prod;
    logic [ACC_W:0]        w_prod_ext;
    logic [ACC_W:0]        w_acc_ext;
    logic [ACC_W:0]        w_sum;
    logic                  w_ovf_now;
    logic [ACC_W-1:0]      w_sat_val;
    logic [ACC_W-1:0]      w_mac_res;

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    // The read for lag 0 is launched on the accept cycle, so inside MAC the
    // RAM output already holds ram[r_k] and the read address runs one ahead.
    always_comb begin
        w_state_nx   = r_state;
        w_k_nx       = r_k;
        w_raddr      = rd_addr;
        w_accept_mac = 1'b0;
        w_capture_b  = 1'b0;
        w_rd_issue   = 1'b0;
        w_drop_set   = 1'b0;
        w_sweep_end  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sin) begin
                    w_state_nx   = S_MAC;
                    w_accept_mac = 1'b1;
                    w_capture_b  = 1'b1;
                    w_raddr      = '0;
                end else if (clr_req) begin
                    w_state_nx = S_CLR;
                end else if (rd_req) begin
                    w_state_nx = S_READ;
                    w_rd_issue = 1'b1;
                end
            end
            S_MAC: begin
                w_raddr     = r_k + LAG_LOG2'(1);
                w_capture_b = 1'b1;
                w_drop_set  = sin;
                w_k_nx      = r_k + LAG_LOG2'(1);
                if (r_k == K_LAST) begin
                    w_state_nx  = S_IDLE;
                    w_sweep_end = 1'b1;
                end
            end
            S_CLR: begin
                w_drop_set = sin;
                w_k_nx     = r_k + LAG_LOG2'(1);
                if (r_k == K_LAST) begin
                    w_state_nx  = S_IDLE;
                    w_sweep_end = 1'b1;
                end
            end
            S_READ: begin
                w_drop_set = sin;
                if (rd_req) begin
                    w_rd_issue = 1'b1;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Arithmetic
    // ------------------------------------------------------------------
    // Operands are extended to the full product width first; the low PW bits
    // of that product are the correct signed or unsigned result.
    always_comb begin
        w_a_ext    = {{DW{L_SGN & r_a_hold[DW-1]}}, r_a_hold};
        w_b_ext    = {{DW{L_SGN & r_b_reg[DW-1]}}, r_b_reg};
        w_prod     = w_a_ext * w_b_ext;
        w_prod_ext = {{(ACC_W+1-PW){L_SGN & w_prod[PW-1]}}, w_prod};
        w_acc_ext  = {L_SGN & r_ram_q[ACC_W-1], r_ram_q};
        w_sum      = w_acc_ext + w_prod_ext;
        if (L_SGN) begin
            w_ovf_now = w_sum[ACC_W] ^ w_sum[ACC_W-1];
            w_sat_val = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            w_ovf_now = w_sum[ACC_W];
            w_sat_val = '1;
        end
        if (w_ovf_now && L_SAT) begin
            w_mac_res = w_sat_val;
        end else begin
            w_mac_res = w_sum[ACC_W-1:0];
        end
    end

    assign w_we    = (r_state == S_MAC) || (r_state == S_CLR);
    assign w_wdata = (r_state == S_MAC) ? w_mac_res : '0;

    // ------------------------------------------------------------------
    // Accumulator RAM: one write port, one registered read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_k] <= w_wdata;
        end
        r_ram_q <= r_mem[w_raddr];
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_a_hold   <= '0;
            r_b_reg    <= '0;
            r_done     <= 1'b0;
            r_drop     <= 1'b0;
            r_ovf      <= 1'b0;
            r_rd_p1    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_k     <= w_k_nx;
            if (w_accept_mac) begin
                r_a_hold <= a;
            end
            if (w_capture_b) begin
                r_b_reg <= b;
            end
            r_done <= w_sweep_end;
            if ((r_state == S_MAC) && w_ovf_now) begin
                r_ovf <= 1'b1;
            end
            if (w_drop_set) begin
                r_drop <= 1'b1;
            end
            // End of a clear sweep wipes both sticky flags.
            if ((r_state == S_CLR) && w_sweep_end) begin
                r_ovf  <= 1'b0;
                r_drop <= 1'b0;
            end
            r_rd_p1    <= w_rd_issue;
            r_rd_valid <= r_rd_p1;
            if (r_rd_p1) begin
                r_rd_data <= r_ram_q;
            end
        end
    end

    assign busy     = (r_state == S_MAC) || (r_state == S_CLR);
    assign done     = r_done;
    assign drop     = r_drop;
    assign ovf      = r_ovf;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_mac_ram_bank.sv
module tb_mac_ram_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    // default-parameter instance
    logic        d_sin, d_clr, d_rdreq;
    logic [7:0]  d_a, d_b, d_rdaddr;
    logic        d_busy, d_done, d_drop, d_ovf, d_rdv;
    logic [31:0] d_rdata;
    logic [31:0] d_exp [256];
    int          d_done_cnt = 0;
    int          d_done_cyc = 0;

    // signed pair (saturating / wrapping) driven in lockstep
    logic        s_sin, s_clr, s_rdreq;
    logic [7:0]  s_a, s_b;
    logic [3:0]  s_rdaddr;
    logic        sa_busy, sa_done, sa_drop, sa_ovf, sa_rdv;
    logic        sb_busy, sb_done, sb_drop, sb_ovf, sb_rdv;
    logic [15:0] sa_rdata, sb_rdata;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] sat0;
        logic [15:0] sat1;
        logic [15:0] wrp0;
        logic [15:0] wrp1;
        logic        ovf_sat;
        logic        ovf_wrp;
    } vec_t;

    vec_t tbl [5];

    mac_ram_bank #(.DW(8), .ACC_W(32), .LAG_LOG2(8), .SIGNED(0), .SATURATE(1)) u_d (
        .clk(clk), .rst_n(rst_n), .sin(d_sin), .clr_req(d_clr), .a(d_a), .b(d_b),
        .busy(d_busy), .done(d_done), .drop(d_drop), .ovf(d_ovf),
        .rd_req(d_rdreq), .rd_addr(d_rdaddr), .rd_valid(d_rdv), .rd_data(d_rdata)
    );

    mac_ram_bank #(.DW(8), .ACC_W(16), .LAG_LOG2(4), .SIGNED(1), .SATURATE(1)) u_ss (
        .clk(clk), .rst_n(rst_n), .sin(s_sin), .clr_req(s_clr), .a(s_a), .b(s_b),
        .busy(sa_busy), .done(sa_done), .drop(sa_drop), .ovf(sa_ovf),
        .rd_req(s_rdreq), .rd_addr(s_rdaddr), .rd_valid(sa_rdv), .rd_data(sa_rdata)
    );

    mac_ram_bank #(.DW(8), .ACC_W(16), .LAG_LOG2(4), .SIGNED(1), .SATURATE(0)) u_sw (
        .clk(clk), .rst_n(rst_n), .sin(s_sin), .clr_req(s_clr), .a(s_a), .b(s_b),
        .busy(sb_busy), .done(sb_done), .drop(sb_drop), .ovf(sb_ovf),
        .rd_req(s_rdreq), .rd_addr(s_rdaddr), .rd_valid(sb_rdv), .rd_data(sb_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (d_done === 1'b1) begin
            d_done_cnt++;
            d_done_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- default instance helpers ----------------
    task automatic d_clear();
        int c0;
        c0 = d_done_cnt;
        d_clr = 1'b1;
        tick();
        d_clr = 1'b0;
        chk("clr_busy_first", d_busy, 1);
        repeat (255) tick();
        chk("clr_busy_last", d_busy, 1);
        tick();
        chk("clr_done", {d_done, d_busy}, 2'b10);
        tick();
        chk("clr_done_count", d_done_cnt - c0, 1);
        chk("clr_flags", {d_ovf, d_drop}, 2'b00);
        for (int k = 0; k < 256; k++) d_exp[k] = '0;
    endtask

    task automatic d_sweep(input logic [7:0] av, input bit ramp, input int sin_k,
                           input int rst_k);
        int c0;
        int t0;
        c0 = d_done_cnt;
        t0 = 0;
        for (int k = 0; k < 256; k++) begin
            d_b = ramp ? 8'(k) : 8'd1;
            if (k == 0) begin
                d_sin = 1'b1;
                d_a   = av;
                t0    = cyc;
            end else begin
                d_sin = (k == sin_k);
            end
            if (k == rst_k) begin
                d_sin = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("rst_busy", d_busy, 0);
                chk("rst_flags", {d_done, d_drop, d_ovf, d_rdv}, 4'b0000);
                return;
            end
            tick();
            if (k == 0) chk("sweep_busy_first", d_busy, 1);
        end
        d_sin = 1'b0;
        d_b   = '0;
        chk("sweep_busy_last", {d_busy, d_done}, 2'b10);
        tick();
        chk("sweep_done", {d_done, d_busy}, 2'b10);
        tick();
        chk("sweep_done_low", d_done, 0);
        chk("sweep_done_count", d_done_cnt - c0, 1);
        chk("sweep_done_latency", d_done_cyc - t0, 257);
        for (int k = 0; k < 256; k++) d_exp[k] = d_exp[k] + 32'(av) * (ramp ? 32'(k) : 32'd1);
    endtask

    task automatic d_read_all();
        for (int i = 0; i < 258; i++) begin
            if (i < 256) begin
                d_rdreq  = 1'b1;
                d_rdaddr = 8'(i);
            end else begin
                d_rdreq = 1'b0;
            end
            if (i >= 2) chk("read_all", {d_rdv, d_rdata}, {1'b1, d_exp[i-2]});
            tick();
        end
        chk("read_all_end", {d_rdv, d_rdata}, {1'b0, d_exp[255]});
    endtask

    // ---------------- signed pair helpers ----------------
    task automatic s_clear();
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        repeat (15) tick();
        chk("s_clr_busy_last", {sa_busy, sb_busy}, 2'b11);
        tick();
        chk("s_clr_done", {sa_done, sb_done, sa_busy, sb_busy}, 4'b1100);
        tick();
        chk("s_clr_ovf", {sa_ovf, sb_ovf}, 2'b00);
    endtask

    task automatic s_sweep(input logic [7:0] av, input logic [7:0] b0, input logic [7:0] b1);
        for (int k = 0; k < 16; k++) begin
            s_b   = (k == 0) ? b0 : ((k == 1) ? b1 : 8'd0);
            s_sin = (k == 0);
            if (k == 0) s_a = av;
            tick();
        end
        s_sin = 1'b0;
        chk("s_sweep_busy_last", {sa_busy, sb_busy}, 2'b11);
        tick();
        chk("s_sweep_done", {sa_done, sb_done, sa_busy, sb_busy}, 4'b1100);
        tick();
    endtask

    task automatic s_read3(input logic [15:0] es0, input logic [15:0] es1,
                           input logic [15:0] ew0, input logic [15:0] ew1);
        logic [3:0]  addrs [3];
        logic [15:0] es [3];
        logic [15:0] ew [3];
        addrs[0] = 4'd0;  addrs[1] = 4'd1;  addrs[2] = 4'd15;
        es[0] = es0; es[1] = es1; es[2] = '0;
        ew[0] = ew0; ew[1] = ew1; ew[2] = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                s_rdreq  = 1'b1;
                s_rdaddr = addrs[i];
            end else begin
                s_rdreq = 1'b0;
            end
            if (i >= 2) begin
                chk("s_read_sat", {sa_rdv, sa_rdata}, {1'b1, es[i-2]});
                chk("s_read_wrap", {sb_rdv, sb_rdata}, {1'b1, ew[i-2]});
            end
            tick();
        end
    endtask

    initial begin
        //              a      b0     b1     sat0      sat1      wrap0     wrap1    ovfS  ovfW
        tbl[0] = '{8'd127, 8'd127, 8'hFD, 16'h3F01, 16'hFE83, 16'h3F01, 16'hFE83, 1'b0, 1'b0};
        tbl[1] = '{8'd127, 8'd127, 8'h80, 16'h7E02, 16'hBF03, 16'h7E02, 16'hBF03, 1'b0, 1'b0};
        tbl[2] = '{8'd26,  8'd17,  8'h80, 16'h7FBC, 16'hB203, 16'h7FBC, 16'hB203, 1'b0, 1'b0};
        tbl[3] = '{8'd127, 8'd1,   8'h80, 16'h7FFF, 16'h8000, 16'h803B, 16'h7283, 1'b1, 1'b1};
        tbl[4] = '{8'hFF,  8'hFF,  8'h00, 16'h7FFF, 16'h8000, 16'h803C, 16'h7283, 1'b1, 1'b1};

        rst_n = 1'b0;
        d_sin = 0; d_clr = 0; d_rdreq = 0; d_a = 0; d_b = 0; d_rdaddr = 0;
        s_sin = 0; s_clr = 0; s_rdreq = 0; s_a = 0; s_b = 0; s_rdaddr = 0;
        repeat (3) tick();
        chk("reset_d", {d_busy, d_done, d_drop, d_ovf, d_rdv, d_rdata}, '0);
        chk("reset_sat", {sa_busy, sa_done, sa_drop, sa_ovf, sa_rdv, sa_rdata}, '0);
        chk("reset_wrap", {sb_busy, sb_done, sb_drop, sb_ovf, sb_rdv, sb_rdata}, '0);
        rst_n = 1'b1;
        tick();

        // ramp sweep: lag k = 3k
        d_clear();
        d_sweep(8'd3, 1'b1, -1, -1);
        d_read_all();

        // consecutive reads 5,6,7 with a sample strobe during READ
        chk("pre_read_drop", d_drop, 0);
        d_rdreq = 1'b1; d_rdaddr = 8'd5;
        chk("r3_valid_t0", d_rdv, 0);
        tick();
        d_rdaddr = 8'd6;
        chk("r3_valid_t1", d_rdv, 0);
        tick();
        d_rdaddr = 8'd7; d_sin = 1'b1; d_a = 8'd9; d_b = 8'd9;
        chk("r3_data5", {d_rdv, d_rdata}, {1'b1, 32'd15});
        tick();
        d_rdreq = 1'b0; d_sin = 1'b0;
        chk("r3_data6", {d_rdv, d_rdata}, {1'b1, 32'd18});
        chk("read_sin_drop", {d_drop, d_busy}, 2'b10);
        tick();
        chk("r3_data7", {d_rdv, d_rdata}, {1'b1, 32'd21});
        tick();
        chk("r3_end", {d_rdv, d_rdata, d_busy}, {1'b0, 32'd21, 1'b0});
        tick();
        chk("read_sin_no_sweep", {d_busy, d_done}, 2'b00);

        // two sweeps accumulate to 7, second one with a stray sample strobe
        d_clear();
        d_sweep(8'd2, 1'b0, -1, -1);
        chk("no_drop_yet", d_drop, 0);
        d_sweep(8'd5, 1'b0, 10, -1);
        chk("mid_sweep_drop", d_drop, 1);
        d_read_all();
        d_clear();
        d_read_all();

        // reset mid-sweep, then recover
        d_sweep(8'd1, 1'b0, 5, -1);
        chk("drop_before_rst", d_drop, 1);
        d_sweep(8'd1, 1'b0, -1, 100);
        tick();
        chk("rst_held_idle", d_busy, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_release_idle", {d_busy, d_done, d_drop}, 3'b000);
        d_clear();
        d_read_all();
        d_sweep(8'd3, 1'b1, -1, -1);
        d_read_all();

        // signed saturate / wrap pair, table driven
        s_clear();
        for (int v = 0; v < 5; v++) begin
            s_sweep(tbl[v].a, tbl[v].b0, tbl[v].b1);
            s_read3(tbl[v].sat0, tbl[v].sat1, tbl[v].wrp0, tbl[v].wrp1);
            chk("s_ovf_sat", sa_ovf, tbl[v].ovf_sat);
            chk("s_ovf_wrap", sb_ovf, tbl[v].ovf_wrp);
        end
        s_clear();
        s_read3(16'h0000, 16'h0000, 16'h0000, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
